// File: rtl/chimp_board_datapath.sv
// ----------------------------------------------------------------------------
// chimp_board_datapath
//   Board-side datapath for the chimp memory game. Holds a 32-cell board
//   (8 columns x 4 rows, index = row*8+col) of 5-bit tile numbers, places the
//   next number on a pseudo-random empty cell on each load pulse, turns player
//   selections into one-cycle press codes and offers a registered read port
//   for the renderer.
//
// Ports
//   clk        system clock
//   iResetn    asynchronous active-low reset
//   iClear     pulse: empty the board, restart numbering at 1
//   iLoad      pulse: place the next number on a random empty cell
//   iSelect    pulse: player pressed the cell at iCursor
//   iCursor    cell under the player cursor
//   iRdCell    renderer read address
//   oRdNum     board[iRdCell], one-cycle latency, 0 = empty
//   oPressNum  press code for the control FSM, 0 when idle
//   oLoadDone  one-cycle pulse in the cycle a placement is written
//   oLoadErr   pulse when iLoad arrives with 32 placements already made
//   oBusy      high while a placement is in progress
//   oHide      high after the first valid press; renderer masks numbers
// ----------------------------------------------------------------------------
module chimp_board_datapath #(
  parameter int unsigned CELLS     = 32,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       iResetn,
  input  logic       iClear,
  input  logic       iLoad,
  input  logic       iSelect,
  input  logic [4:0] iCursor,
  input  logic [4:0] iRdCell,
  output logic [4:0] oRdNum,
  output logic [5:0] oPressNum,
  output logic       oLoadDone,
  output logic       oLoadErr,
  output logic       oBusy,
  output logic       oHide
);

  typedef enum logic [1:0] {StIdle, StSeek, StPlace} state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic [7:0]  r_lfsr;
  logic [4:0]  r_board [CELLS];
  logic [4:0]  r_probe;
  logic [5:0]  r_next;
  logic [5:0]  r_count;
  logic [5:0]  r_press;
  logic        r_hide;
  logic [4:0]  r_rd;

  logic        w_full;
  logic        w_probe_empty;
  logic        w_load_go;
  logic        w_place_wr;
  logic        w_sel_ok;

  assign w_full        = (r_count == 6'(CELLS));
  assign w_probe_empty = (r_board[r_probe] == 5'd0);
  assign w_load_go     = (r_state == StIdle) && !iClear && iLoad && !w_full;
  assign w_place_wr    = (r_state == StPlace) && !iClear;
  // Refusing a press while the previous code is still out keeps oPressNum
  // from ever being nonzero on two consecutive cycles.
  assign w_sel_ok      = (r_state == StIdle) && !iClear && !iLoad && iSelect &&
                         (r_board[iCursor] != 5'd0) && (r_press == 6'd0);

  // Free-running Fibonacci LFSR, taps 8,6,5,4; keeps running through iClear.
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_d = r_state;
    if (iClear) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle:  if (iLoad && !w_full) w_state_d = StSeek;
        StSeek:  if (w_probe_empty) w_state_d = StPlace;
        StPlace: w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    oBusy     = (r_state != StIdle);
    oLoadDone = (r_state == StPlace) && !iClear;
    oLoadErr  = (r_state == StIdle) && iLoad && w_full && !iClear;
    oPressNum = iClear ? 6'd0 : r_press;
  end

  assign oHide  = r_hide;
  assign oRdNum = r_rd;

  // Probe pointer: seeded from the LFSR, then walks forward (5-bit wrap).
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      r_probe <= 5'd0;
    end else if (w_load_go) begin
      r_probe <= r_lfsr[4:0];
    end else if ((r_state == StSeek) && !w_probe_empty) begin
      r_probe <= r_probe + 5'd1;
    end
  end

  // Board storage
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      for (int i = 0; i < CELLS; i++) r_board[i] <= 5'd0;
    end else if (iClear) begin
      for (int i = 0; i < CELLS; i++) r_board[i] <= 5'd0;
    end else if (w_place_wr) begin
      // A 32nd placement writes 0; the control FSM never asks for it.
      r_board[r_probe] <= r_next[4:0];
    end else if (w_sel_ok) begin
      r_board[iCursor] <= 5'd0;
    end
  end

  // Numbering and placement count
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      r_next  <= 6'd1;
      r_count <= 6'd0;
    end else if (iClear) begin
      r_next  <= 6'd1;
      r_count <= 6'd0;
    end else if (w_place_wr) begin
      r_next  <= r_next + 6'd1;
      r_count <= r_count + 6'd1;
    end
  end

  // Press code and hide flag
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      r_press <= 6'd0;
      r_hide  <= 1'b0;
    end else if (iClear) begin
      r_press <= 6'd0;
      r_hide  <= 1'b0;
    end else if (w_sel_ok) begin
      r_press <= {1'b0, r_board[iCursor]};
      r_hide  <= 1'b1;
    end else begin
      r_press <= 6'd0;
    end
  end

  // Renderer read port: samples the board as left by the previous edge.
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      r_rd <= 5'd0;
    end else begin
      r_rd <= r_board[iRdCell];
    end
  end

endmodule

// File: tb/tb_chimp_board_datapath.sv
module tb_chimp_board_datapath;

  logic       clk = 1'b0;
  logic       iResetn = 1'b0;
  logic       iClear = 1'b0;
  logic       iLoad = 1'b0;
  logic       iSelect = 1'b0;
  logic [4:0] iCursor = 5'd0;
  logic [4:0] iRdCell = 5'd0;
  logic [4:0] oRdNum;
  logic [5:0] oPressNum;
  logic       oLoadDone;
  logic       oLoadErr;
  logic       oBusy;
  logic       oHide;

  chimp_board_datapath dut (
    .clk       (clk),
    .iResetn   (iResetn),
    .iClear    (iClear),
    .iLoad     (iLoad),
    .iSelect   (iSelect),
    .iCursor   (iCursor),
    .iRdCell   (iRdCell),
    .oRdNum    (oRdNum),
    .oPressNum (oPressNum),
    .oLoadDone (oLoadDone),
    .oLoadErr  (oLoadErr),
    .oBusy     (oBusy),
    .oHide     (oHide)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A placement is resolved the moment it is accepted: the target is the
  // first empty cell at or after the LFSR candidate, and it completes after
  // (occupied cells skipped + 1) further cycles.
  int         m_board [32];
  int         m_next, m_count, m_press, m_target, m_rem, m_rd;
  bit         m_active, m_hide;
  logic [7:0] m_lfsr;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  task automatic model_reset();
    foreach (m_board[i]) m_board[i] = 0;
    m_next = 1; m_count = 0; m_press = 0; m_target = 0; m_rem = 0; m_rd = 0;
    m_active = 0; m_hide = 0; m_lfsr = 8'hA5;
  endtask

  task automatic model_step();
    int nrd, pp, c, occ;
    nrd = m_board[iRdCell];
    pp  = m_press;
    m_press = 0;
    if (iClear) begin
      foreach (m_board[i]) m_board[i] = 0;
      m_next = 1; m_count = 0; m_hide = 0; m_active = 0;
    end else if (m_active) begin
      if (m_rem == 0) begin
        m_board[m_target] = m_next % 32;
        m_next++; m_count++; m_active = 0;
      end else begin
        m_rem--;
      end
    end else if (iLoad) begin
      if (m_count < 32) begin
        c = int'(m_lfsr[4:0]); occ = 0;
        while (m_board[c] != 0) begin c = (c + 1) % 32; occ++; end
        m_target = c; m_rem = occ + 1; m_active = 1;
      end
    end else if (iSelect && m_board[iCursor] != 0 && pp == 0) begin
      m_press = m_board[iCursor];
      m_board[iCursor] = 0;
      m_hide = 1;
    end
    m_rd   = nrd;
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge iResetn);
      if (!iResetn) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("rd_num",    int'(oRdNum),    m_rd);
      chk("press_num", int'(oPressNum), iClear ? 0 : m_press);
      chk("load_done", int'(oLoadDone), int'(m_active && m_rem == 0 && !iClear));
      chk("load_err",  int'(oLoadErr),  int'(!m_active && iLoad && m_count >= 32 && !iClear));
      chk("busy",      int'(oBusy),     int'(m_active));
      chk("hide",      int'(oHide),     int'(m_hide));
    end
  end

  // ---------------- stimulus helpers ----------------
  int sw [32];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_wait(output int lat);
    int got;
    iLoad = 1'b1;
    tick();
    iLoad = 1'b0;
    lat = 1;
    while (!oLoadDone && lat < 40) begin
      tick();
      lat++;
    end
    got = int'(oLoadDone);
    chk("load_done_seen", got, 1);
    tick();
  endtask

  task automatic sweep();
    for (int c = 0; c < 32; c++) begin
      iRdCell = 5'(c);
      tick();
      sw[c] = int'(oRdNum);
    end
  endtask

  function automatic int count_nz();
    int n = 0;
    foreach (sw[i]) if (sw[i] != 0) n++;
    return n;
  endfunction

  function automatic int find_val(input int v);
    foreach (sw[i]) if (sw[i] == v) return i;
    return -1;
  endfunction

  task automatic sel(input int c, output int p);
    iSelect = 1'b1;
    iCursor = 5'(c);
    tick();
    iSelect = 1'b0;
    p = int'(oPressNum);
  endtask

  task automatic pulse_clear();
    iClear = 1'b1;
    tick();
    iClear = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, p, c1, ce, sum, dsum, bound;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd",    int'(oRdNum), 0);
    chk("rst_press", int'(oPressNum), 0);
    chk("rst_busy",  int'(oBusy), 0);
    chk("rst_hide",  int'(oHide), 0);
    iResetn = 1'b1;
    tick();

    // Three loads on an empty board
    for (int i = 0; i < 3; i++) begin
      load_wait(lat);
      if (i == 0) chk("first_latency", lat, 2);
    end
    sweep();
    sum = 0;
    foreach (sw[i]) sum += sw[i];
    chk("three_nonzero", count_nz(), 3);
    chk("three_sum", sum, 6);
    chk("has_1", int'(find_val(1) >= 0), 1);
    chk("has_3", int'(find_val(3) >= 0), 1);
    chk("hide_before_press", int'(oHide), 0);

    // Fourth tile, then press tile 1 twice
    load_wait(lat);
    sweep();
    c1 = find_val(1);
    ce = find_val(0);
    chk("four_nonzero", count_nz(), 4);
    sel(c1, p);
    chk("press_one", p, 1);
    chk("hide_after_press", int'(oHide), 1);
    tick();
    chk("press_pulse_len", int'(oPressNum), 0);
    sel(c1, p);
    chk("press_again", p, 0);
    sel(ce, p);
    chk("press_empty", p, 0);
    chk("hide_kept", int'(oHide), 1);
    sweep();
    chk("pressed_cell_clear", sw[c1], 0);
    chk("after_press_nonzero", count_nz(), 3);

    // Randomised traffic checked by the per-cycle compare
    for (int i = 0; i < 3000; i++) begin
      iLoad   = ($urandom_range(0, 7) == 0);
      iSelect = ($urandom_range(0, 3) == 0);
      iClear  = ($urandom_range(0, 99) == 0);
      iCursor = 5'($urandom_range(0, 31));
      iRdCell = 5'($urandom_range(0, 31));
      tick();
    end
    iLoad = 1'b0; iSelect = 1'b0; iClear = 1'b0;
    bound = 0;
    while (oBusy && bound < 50) begin tick(); bound++; end
    chk("random_drain", int'(oBusy), 0);

    // Fill all 32 cells, then overflow
    pulse_clear();
    chk("clear_hide", int'(oHide), 0);
    for (int i = 0; i < 32; i++) load_wait(lat);
    sweep();
    chk("full_nonzero", count_nz(), 31);
    iLoad = 1'b1;
    #1;
    chk("overflow_err", int'(oLoadErr), 1);
    tick();
    iLoad = 1'b0;
    #1;
    chk("overflow_err_len", int'(oLoadErr), 0);
    chk("overflow_not_busy", int'(oBusy), 0);
    sweep();
    chk("overflow_board", count_nz(), 31);

    // Clear during SEEK
    pulse_clear();
    load_wait(lat);
    load_wait(lat);
    iLoad = 1'b1;
    tick();
    iLoad = 1'b0;
    chk("seek_busy", int'(oBusy), 1);
    iClear = 1'b1;
    #1;
    chk("seek_clear_nodone", int'(oLoadDone), 0);
    tick();
    iClear = 1'b0;
    dsum = 0;
    for (int i = 0; i < 5; i++) begin dsum += int'(oLoadDone); tick(); end
    chk("seek_abandon", dsum, 0);
    sweep();
    chk("seek_clear_board", count_nz(), 0);
    load_wait(lat);
    sweep();
    chk("seek_next_is_1", int'(find_val(1) >= 0), 1);

    // Reset dropped mid-PLACE
    load_wait(lat);
    iLoad = 1'b1;
    tick();
    iLoad = 1'b0;
    bound = 0;
    while (!(m_active && m_rem == 0) && bound < 40) begin tick(); bound++; end
    chk("reach_place", int'(m_active && m_rem == 0), 1);
    iResetn = 1'b0;
    #1;
    chk("rst_place_nodone", int'(oLoadDone), 0);
    tick();
    iResetn = 1'b1;
    tick();
    dsum = 0;
    for (int i = 0; i < 4; i++) begin dsum += int'(oLoadDone); tick(); end
    chk("rst_abandon", dsum, 0);
    sweep();
    chk("rst_board", count_nz(), 0);
    load_wait(lat);
    chk("rst_first_latency", lat, 2);
    sweep();
    chk("rst_next_is_1", int'(find_val(1) >= 0), 1);
    chk("rst_one_tile", count_nz(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
